f_pc_reg: RTL and testbench

Fetch-stage PC register and F/D pipeline register of the five-stage MIPS pipeline with precise exceptions. It holds the fetch PC and drives the instruction-memory address. It checks the fetch address for AdEL, and on each clock edge captures the fetched instruction, its PC, its delay-slot flag and its exception code into the F/D register. It consumes the next-PC value and delay-slot flag produced by the next-PC selector, and applies stall, exception-request and eret flush control.

---
 rtl/f_pc_reg.sv | 125 ++++++++++++
 tb/tb_f_pc_reg.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/f_pc_reg.sv
// -----------------------------------------------------------------------------
// f_pc_reg
//   Fetch-stage PC register plus the F/D pipeline register of a five-stage MIPS
//   pipeline with precise exceptions. The PC register drives the instruction
//   memory address directly. The fetched word is screened for AdEL, and then
//   latched into F/D with its PC, delay-slot flag and exception code.
//
//   Update priority on every rising edge, highest first:
//     reset low  -> PC and F/D return to their reset values
//     Req        -> jump to EXC_ENTRY and flush D (overrides stall and eret)
//     stall      -> PC and F/D hold (eret_D ignored)
//     eret_D     -> PC <= NPC_F and flush D (eret has no delay slot)
//     otherwise  -> PC <= NPC_F and capture the fetched entry
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous reset, active low
//   NPC_F         in   next fetch PC from the next-PC selector
//   BD_F          in   instruction in F is a delay slot
//   stall         in   hazard-unit stall request
//   Req           in   exception/interrupt taken this cycle
//   eret_D        in   eret is in D this cycle
//   i_inst_rdata  in   instruction word at i_inst_addr (combinational IM)
//   i_inst_addr   out  current fetch PC
//   INSTR_D       out  F/D instruction
//   PC_D          out  F/D PC
//   BD_D          out  F/D delay-slot flag
//   EXC_D         out  F/D exception code (0 none, 4 AdEL)
// -----------------------------------------------------------------------------
module f_pc_reg #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_TOP    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC_F,
  input  logic        BD_F,
  input  logic        stall,
  input  logic        Req,
  input  logic        eret_D,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] INSTR_D,
  output logic [31:0] PC_D,
  output logic        BD_D,
  output logic [4:0]  EXC_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_fd_q, pc_fd_d;
  logic        bd_q,    bd_d;
  logic [4:0]  exc_q,   exc_d;

  logic        adel_f;
  logic [31:0] instr_f;
  logic [4:0]  exc_f;

  // Fetch-address check. Unsigned compares; out-of-range or misaligned PCs
  // are fetched as a nop and tagged AdEL so the fault is raised precisely.
  always_comb begin
    adel_f  = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_TOP);
    instr_f = adel_f ? 32'h0 : i_inst_rdata;
    exc_f   = adel_f ? EXC_ADEL : EXC_NONE;
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_fd_d = pc_fd_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    if (Req) begin
      // Bubble keeps a meaningful PC so EPC of an empty slot stays correct.
      pc_d    = EXC_ENTRY;
      instr_d = 32'h0;
      pc_fd_d = EXC_ENTRY;
      bd_d    = 1'b0;
      exc_d   = EXC_NONE;
    end else if (stall) begin
      // hold everything
    end else if (eret_D) begin
      // The word fetched behind eret is discarded.
      pc_d    = NPC_F;
      instr_d = 32'h0;
      pc_fd_d = pc_q;
      bd_d    = 1'b0;
      exc_d   = EXC_NONE;
    end else begin
      pc_d    = NPC_F;
      instr_d = instr_f;
      pc_fd_d = pc_q;
      bd_d    = BD_F;
      exc_d   = exc_f;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      pc_fd_q <= PC_RESET;
      bd_q    <= 1'b0;
      exc_q   <= EXC_NONE;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_fd_q <= pc_fd_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
    end
  end

  assign i_inst_addr = pc_q;
  assign INSTR_D     = instr_q;
  assign PC_D        = pc_fd_q;
  assign BD_D        = bd_q;
  assign EXC_D       = exc_q;

endmodule

// File: tb/tb_f_pc_reg.sv
module tb_f_pc_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC_F;
  logic        BD_F;
  logic        stall;
  logic        Req;
  logic        eret_D;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] INSTR_D;
  logic [31:0] PC_D;
  logic        BD_D;
  logic [4:0]  EXC_D;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  f_pc_reg dut (
    .clk          (clk),
    .reset        (reset),
    .NPC_F        (NPC_F),
    .BD_F         (BD_F),
    .stall        (stall),
    .Req          (Req),
    .eret_D       (eret_D),
    .i_inst_rdata (i_inst_rdata),
    .i_inst_addr  (i_inst_addr),
    .INSTR_D      (INSTR_D),
    .PC_D         (PC_D),
    .BD_D         (BD_D),
    .EXC_D        (EXC_D)
  );

  // Address-dependent IM contents so every fetched word is distinct.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  always_comb i_inst_rdata = im_word(i_inst_addr);

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr,
                           input logic [31:0] instr, input logic [31:0] pcd,
                           input logic bd, input logic [4:0] exc);
    check_val({tag, ".addr"},  i_inst_addr, addr);
    check_val({tag, ".instr"}, INSTR_D, instr);
    check_val({tag, ".pc_d"},  PC_D, pcd);
    check_val({tag, ".bd"},    {31'b0, BD_D}, {31'b0, bd});
    check_val({tag, ".exc"},   {27'b0, EXC_D}, {27'b0, exc});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; NPC_F = 32'h0; BD_F = 1'b0; stall = 1'b0; Req = 1'b0; eret_D = 1'b0;
    #2;
    step;
    check_all("reset", 32'h3000, 32'h0, 32'h3000, 1'b0, 5'd0);

    // free run
    reset = 1'b1;
    NPC_F = 32'h3004; step;
    check_all("run0", 32'h3004, im_word(32'h3000), 32'h3000, 1'b0, 5'd0);
    NPC_F = 32'h3008; step;
    check_all("run1", 32'h3008, im_word(32'h3004), 32'h3004, 1'b0, 5'd0);
    NPC_F = 32'h300C; step;
    check_all("run2", 32'h300C, im_word(32'h3008), 32'h3008, 1'b0, 5'd0);

    // stall for 3 edges at PC=300C
    stall = 1'b1; NPC_F = 32'h3010;
    for (int i = 0; i < 3; i++) begin
      step;
      check_all("stall", 32'h300C, im_word(32'h3008), 32'h3008, 1'b0, 5'd0);
    end
    stall = 1'b0; step;
    check_all("resume", 32'h3010, im_word(32'h300C), 32'h300C, 1'b0, 5'd0);

    // delay slot at PC=3010
    BD_F = 1'b1; NPC_F = 32'h3014; step;
    check_all("bd1", 32'h3014, im_word(32'h3010), 32'h3010, 1'b1, 5'd0);
    BD_F = 1'b0; NPC_F = 32'h3018; step;
    check_all("bd0", 32'h3018, im_word(32'h3014), 32'h3014, 1'b0, 5'd0);

    // AdEL: misaligned, above top, below base; then the legal boundaries
    NPC_F = 32'h3002; step;
    check_all("adel_pre", 32'h3002, im_word(32'h3018), 32'h3018, 1'b0, 5'd0);
    NPC_F = 32'h7000; step;
    check_all("adel_mis", 32'h7000, 32'h0, 32'h3002, 1'b0, 5'd4);
    NPC_F = 32'h2FFC; step;
    check_all("adel_hi", 32'h2FFC, 32'h0, 32'h7000, 1'b0, 5'd4);
    NPC_F = 32'h6FFC; step;
    check_all("adel_lo", 32'h6FFC, 32'h0, 32'h2FFC, 1'b0, 5'd4);
    NPC_F = 32'h3000; step;
    check_all("top_ok", 32'h3000, im_word(32'h6FFC), 32'h6FFC, 1'b0, 5'd0);
    NPC_F = 32'h3020; step;
    check_all("base_ok", 32'h3020, im_word(32'h3000), 32'h3000, 1'b0, 5'd0);

    // Req together with stall (and BD_F) at PC=3020
    Req = 1'b1; stall = 1'b1; BD_F = 1'b1; NPC_F = 32'h3024; step;
    check_all("req_stall", 32'h4180, 32'h0, 32'h4180, 1'b0, 5'd0);
    Req = 1'b0; stall = 1'b0; BD_F = 1'b0; NPC_F = 32'h4184; step;
    check_all("handler", 32'h4184, im_word(32'h4180), 32'h4180, 1'b0, 5'd0);
    NPC_F = 32'h4190; step;
    check_all("to4190", 32'h4190, im_word(32'h4184), 32'h4184, 1'b0, 5'd0);

    // eret under stall: nothing moves
    eret_D = 1'b1; stall = 1'b1; NPC_F = 32'h3040; step;
    check_all("eret_stall", 32'h4190, im_word(32'h4184), 32'h4184, 1'b0, 5'd0);
    stall = 1'b0; step;
    check_all("eret", 32'h3040, 32'h0, 32'h4190, 1'b0, 5'd0);

    // Req with eret: Req rule applies
    Req = 1'b1; eret_D = 1'b1; NPC_F = 32'h3044; step;
    check_all("req_eret", 32'h4180, 32'h0, 32'h4180, 1'b0, 5'd0);

    // one normal step, then reset while stall and Req are high
    Req = 1'b0; eret_D = 1'b0; NPC_F = 32'h4184; step;
    check_all("pre_rst", 32'h4184, im_word(32'h4180), 32'h4180, 1'b0, 5'd0);
    reset = 1'b0; stall = 1'b1; Req = 1'b1; step;
    check_all("rst_mid", 32'h3000, 32'h0, 32'h3000, 1'b0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
